// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder_if
// Brief    : Request/response bundle between the M-stage pipeline and the
//            data-memory responder.
// Revision : 1.0
// ============================================================================
interface dm_responder_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_pc;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Brief    : Fixed-latency load/store responder over an internal word array,
//            cleared by a sweep after reset.
// Revision : 1.0
// ============================================================================
module dm_responder #(
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 3072,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  dm
);
    localparam int                   c_idx_w  = ADDR_W - 2;
    localparam int                   c_mem_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]           c_lat_m1 = 4'(LATENCY - 1);
    localparam logic                 c_lat1   = (LATENCY == 1);
    localparam logic [c_mem_aw-1:0]  c_last   = c_mem_aw'(DEPTH - 1);
    localparam logic [c_idx_w:0]     c_depth  = (c_idx_w + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_mem_aw-1:0] r_sweep;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_pc;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_access;
    logic                w_we;
    logic [1:0]          w_size;
    logic                w_sext;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_wdata;
    logic [31:0]         w_pc;
    logic [c_idx_w-1:0]  w_idx;
    logic                w_err;
    logic [31:0]         w_rd_word;
    logic [3:0]          w_lane_mask;
    logic [31:0]         w_lane_data;
    logic [31:0]         w_merged;
    logic [31:0]         w_shift;
    logic [31:0]         w_load;

    assign w_accept = dm.req_valid && r_req_ready;
    assign w_access = (r_state == ST_WAIT && r_cnt == 4'd1) || (c_lat1 && w_accept);

    // With unit latency the access happens on the accept edge itself, so it
    // must see the live request rather than the latched copy.
    assign w_we    = c_lat1 ? dm.req_we    : r_we;
    assign w_size  = c_lat1 ? dm.req_size  : r_size;
    assign w_sext  = c_lat1 ? dm.req_sext  : r_sext;
    assign w_addr  = c_lat1 ? dm.req_addr  : r_addr;
    assign w_wdata = c_lat1 ? dm.req_wdata : r_wdata;
    assign w_pc    = c_lat1 ? dm.req_pc    : r_pc;

    assign w_idx     = w_addr[ADDR_W-1:2];
    assign w_err     = (w_size == 2'd3)
                    || (w_size == 2'd1 && w_addr[0])
                    || (w_size == 2'd2 && w_addr[1:0] != 2'b00)
                    || ({1'b0, w_idx} >= c_depth);
    assign w_rd_word = r_mem[w_idx[c_mem_aw-1:0]];

    always_comb begin
        w_lane_mask = 4'b0000;
        w_lane_data = 32'h0;
        w_merged    = 32'h0;
        w_load      = 32'h0;
        case (w_size)
            2'd0: begin
                w_lane_mask = 4'b0001 << w_addr[1:0];
                w_lane_data = {4{w_wdata[7:0]}};
            end
            2'd1: begin
                w_lane_mask = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_wdata[15:0]}};
            end
            2'd2: begin
                w_lane_mask = 4'b1111;
                w_lane_data = w_wdata;
            end
            default: w_lane_mask = 4'b0000;
        endcase
        for (int k = 0; k < 4; k++) begin
            w_merged[8*k +: 8] = w_lane_mask[k] ? w_lane_data[8*k +: 8] : w_rd_word[8*k +: 8];
        end
        w_shift = w_rd_word >> {w_addr[1:0], 3'b000};
        case (w_size)
            2'd0:    w_load = {{24{w_sext & w_shift[7]}},  w_shift[7:0]};
            2'd1:    w_load = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_rd_word;
        endcase
    end

    // Array has no reset so it can map onto RAM; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_sweep] <= 32'h0;
        end else if (w_access && w_we && !w_err) begin
            r_mem[w_idx[c_mem_aw-1:0]] <= w_merged;
`ifndef SYNTHESIS
            $display("@%08h: *%08h <= %08h", w_pc, 32'({w_idx, 2'b00}), w_merged);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_sweep     <= '0;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_sext      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_pc        <= 32'h0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_we) ? 32'h0 : w_load;
            end
            case (r_state)
                ST_INIT: begin
                    r_sweep <= r_sweep + 1'b1;
                    if (r_sweep == c_last) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= dm.req_we;
                        r_size      <= dm.req_size;
                        r_sext      <= dm.req_sext;
                        r_addr      <= dm.req_addr;
                        r_wdata     <= dm.req_wdata;
                        r_pc        <= dm.req_pc;
                        r_cnt       <= c_lat_m1;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= c_lat1 ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign dm.req_ready = r_req_ready;
    assign dm.rsp_valid = r_rsp_valid;
    assign dm.rsp_rdata = r_rsp_rdata;
    assign dm.rsp_err   = r_rsp_err;
    assign dm.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Brief    : Directed bench for dm_responder at latencies 2 (full depth), 1, 3.
// Revision : 1.0
// ============================================================================
module tb_dm_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst, valid, we, sext;
    logic [1:0]  size  [3];
    logic [13:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] pc    [3];
    wire  [2:0]  rdy, rspv, rerr, bsy;
    wire  [31:0] rdat  [3];

    int n_total = 0;
    int n_bad   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int c_lat = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);
            localparam int c_dep = (gi == 0) ? 3072 : 16;
            dm_responder_if #(.ADDR_W(14)) bus ();
            assign bus.req_valid = valid[gi];
            assign bus.req_we    = we[gi];
            assign bus.req_size  = size[gi];
            assign bus.req_sext  = sext[gi];
            assign bus.req_addr  = addr[gi];
            assign bus.req_wdata = wdata[gi];
            assign bus.req_pc    = pc[gi];
            assign rdy[gi]       = bus.req_ready;
            assign rspv[gi]      = bus.rsp_valid;
            assign rerr[gi]      = bus.rsp_err;
            assign bsy[gi]       = bus.busy;
            assign rdat[gi]      = bus.rsp_rdata;
            dm_responder #(.ADDR_W(14), .DEPTH(c_dep), .LATENCY(c_lat)) u_dut (
                .clk   (clk),
                .reset (rst[gi]),
                .dm    (bus.slave)
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic chk_reset_vals(input int d, input string tag);
        chk({tag, ".ready"}, rdy[d],  1'b0);
        chk({tag, ".busy"},  bsy[d],  1'b1);
        chk({tag, ".valid"}, rspv[d], 1'b0);
        chk({tag, ".rdata"}, rdat[d], 32'h0);
        chk({tag, ".err"},   rerr[d], 1'b0);
    endtask

    task automatic wait_init(input int d, input int depth);
        int n;
        rst[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < depth + 100) begin
            tick();
            n++;
        end
        chk("init_len", n, depth);
    endtask

    // Fields are scrambled right after the accept edge; the response must not care.
    task automatic do_req(input int d, input bit w, input logic [1:0] sz, input bit sx,
                          input logic [13:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit e, output int lat);
        int k;
        we[d] = w; size[d] = sz; sext[d] = sx; addr[d] = a; wdata[d] = wd;
        pc[d] = 32'h0000_3000; valid[d] = 1'b1;
        k = 0;
        while (!rdy[d] && k < 50) begin
            tick();
            k++;
        end
        if (!rdy[d]) begin
            chk("ready_timeout", rdy[d], 1'b1);
            valid[d] = 1'b0; rd = 32'h0; e = 1'b0; lat = 0;
            return;
        end
        tick();
        valid[d] = 1'b0; we[d] = ~w; size[d] = 2'd3; sext[d] = ~sx;
        addr[d] = a ^ 14'h4; wdata[d] = ~wd; pc[d] = 32'hFFFF_FFFF;
        lat = 1;
        while (!rspv[d] && lat < 20) begin
            tick();
            lat++;
        end
        rd = rdat[d];
        e  = rerr[d];
        tick();
        chk("pulse_end",  rspv[d], 1'b0);
        chk("ready_back", rdy[d],  1'b1);
    endtask

    task automatic op(input int d, input string tag, input bit w, input logic [1:0] sz,
                      input bit sx, input logic [13:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd;
        bit          e;
        int          l;
        do_req(d, w, sz, sx, a, wd, rd, e, l);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"},   e,  exp_err);
        chk({tag, ".lat"},   l,  lat_of(d));
    endtask

    task automatic b2b(input int d);
        int acc[$];
        int pulses;
        int l;
        l = lat_of(d);
        we[d] = 1'b1; size[d] = 2'd2; sext[d] = 1'b0; addr[d] = 14'h4;
        wdata[d] = 32'hCAFE_0000 | 32'(d); pc[d] = 32'h0000_4000; valid[d] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (rdy[d]) acc.push_back(c);
            if (rspv[d]) pulses++;
            tick();
        end
        valid[d] = 1'b0;
        repeat (5) begin
            if (rspv[d]) pulses++;
            tick();
        end
        chk("b2b_count", acc.size(), 12 / (l + 1));
        for (int i = 1; i < acc.size(); i++) begin
            chk("b2b_gap", acc[i] - acc[i-1], l + 1);
        end
        chk("b2b_pulses", pulses, acc.size());
    endtask

    initial begin
        int pulses;
        rst = 3'b000; valid = 3'b000; we = 3'b000; sext = 3'b000;
        for (int i = 0; i < 3; i++) begin
            size[i] = 2'd0; addr[i] = 14'h0; wdata[i] = 32'h0; pc[i] = 32'h0;
        end
        repeat (3) tick();
        chk_reset_vals(0, "rst");
        wait_init(0, 3072);

        op(0, "lw_0",     0, 2'd2, 0, 14'h0000, 32'h0,        32'h0,        0);
        op(0, "sw_10",    1, 2'd2, 0, 14'h0010, 32'h12345678, 32'h0,        0);
        op(0, "lw_10",    0, 2'd2, 0, 14'h0010, 32'h0,        32'h12345678, 0);
        op(0, "sb_13",    1, 2'd0, 0, 14'h0013, 32'h000000AB, 32'h0,        0);
        op(0, "lw_10b",   0, 2'd2, 0, 14'h0010, 32'h0,        32'hAB345678, 0);
        op(0, "lb_13",    0, 2'd0, 1, 14'h0013, 32'h0,        32'hFFFFFFAB, 0);
        op(0, "lbu_13",   0, 2'd0, 0, 14'h0013, 32'h0,        32'h000000AB, 0);
        op(0, "lh_12",    0, 2'd1, 1, 14'h0012, 32'h0,        32'hFFFFAB34, 0);
        op(0, "lhu_10",   0, 2'd1, 0, 14'h0010, 32'h0,        32'h00005678, 0);
        op(0, "sh_16",    1, 2'd1, 0, 14'h0016, 32'h1234BEEF, 32'h0,        0);
        op(0, "lw_14",    0, 2'd2, 0, 14'h0014, 32'h0,        32'hBEEF0000, 0);
        op(0, "lh_16",    0, 2'd1, 1, 14'h0016, 32'h0,        32'hFFFFBEEF, 0);
        op(0, "sw_11",    1, 2'd2, 0, 14'h0011, 32'hFFFFFFFF, 32'h0,        1);
        op(0, "lw_10c",   0, 2'd2, 0, 14'h0010, 32'h0,        32'hAB345678, 0);
        op(0, "lh_13",    0, 2'd1, 1, 14'h0013, 32'h0,        32'h0,        1);
        op(0, "lw_3000",  0, 2'd2, 0, 14'h3000, 32'h0,        32'h0,        1);
        op(0, "size3",    0, 2'd3, 0, 14'h0010, 32'h0,        32'h0,        1);
        op(0, "sw_3000",  1, 2'd2, 0, 14'h3000, 32'h00000001, 32'h0,        1);
        op(0, "lw_0b",    0, 2'd2, 0, 14'h0000, 32'h0,        32'h0,        0);
        op(0, "sw_2ffc",  1, 2'd2, 0, 14'h2FFC, 32'hA5A5A5A5, 32'h0,        0);
        op(0, "lw_2ffc",  0, 2'd2, 0, 14'h2FFC, 32'h0,        32'hA5A5A5A5, 0);
        repeat (3) tick();
        chk("rdata_hold", rdat[0], 32'hA5A5A5A5);

        // Reset while a store is in flight.
        we[0] = 1'b1; size[0] = 2'd2; sext[0] = 1'b0; addr[0] = 14'h0020;
        wdata[0] = 32'hDEADBEEF; pc[0] = 32'h0000_3004; valid[0] = 1'b1;
        chk("mo_ready", rdy[0], 1'b1);
        tick();
        valid[0] = 1'b0;
        chk("mo_busy", bsy[0], 1'b1);
        rst[0] = 1'b0;
        #1;
        chk_reset_vals(0, "mo");
        pulses = 0;
        repeat (4) begin
            if (rspv[0]) pulses++;
            tick();
        end
        chk("mo_nopulse", pulses, 0);
        wait_init(0, 3072);
        op(0, "mo_lw_20", 0, 2'd2, 0, 14'h0020, 32'h0, 32'h0, 0);
        op(0, "mo_lw_10", 0, 2'd2, 0, 14'h0010, 32'h0, 32'h0, 0);

        wait_init(1, 16);
        b2b(1);
        op(1, "l1_lw4",  0, 2'd2, 0, 14'h0004, 32'h0,        32'hCAFE0001, 0);
        op(1, "l1_sb5",  1, 2'd0, 0, 14'h0005, 32'h00000077, 32'h0,        0);
        op(1, "l1_lw4b", 0, 2'd2, 0, 14'h0004, 32'h0,        32'hCAFE7701, 0);

        wait_init(2, 16);
        b2b(2);
        op(2, "l3_lw4",  0, 2'd2, 0, 14'h0004, 32'h0,        32'hCAFE0002, 0);
        op(2, "l3_sh6",  1, 2'd1, 0, 14'h0006, 32'h00009876, 32'h0,        0);
        op(2, "l3_lw4b", 0, 2'd2, 0, 14'h0004, 32'h0,        32'h98760002, 0);
        op(2, "l3_lw8",  0, 2'd2, 0, 14'h0008, 32'h0,        32'h0,        0);
        op(2, "l3_oob",  0, 2'd2, 0, 14'h0040, 32'h0,        32'h0,        1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
